// File: rtl/input_conditioner_pkg.sv
// rtl/input_conditioner_pkg.sv - shared constants and helpers for the PDU input conditioner
// Optional auto-repeat build: INPUT_CONDITIONER_REPEAT_EN.
package input_conditioner_pkg;

  localparam int DB_CYCLES_100MHZ_10MS = 1000000;
  localparam int PDU_CH                = 21;

  localparam int STEP    = 0;
  localparam int CONT    = 1;
  localparam int CHK     = 2;
  localparam int ENT     = 3;
  localparam int DEL     = 4;
  localparam int HD_BASE = 5;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// rtl/input_conditioner_channel.sv - one channel: synchroniser, debounce counter, edge pulses
// Hold/auto-repeat counter present only with INPUT_CONDITIONER_REPEAT_EN.
module cond_channel
  import input_conditioner_pkg::*;
#(
  parameter int DB_CYCLES   = 4,
  parameter int SYNC_STAGES = 2
`ifdef INPUT_CONDITIONER_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 3,
  parameter bit REPEAT_ON     = 1'b1
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = cnt_w(DB_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;
  logic                   toggle;

`ifdef INPUT_CONDITIONER_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW       = cnt_w(HOLD_MAX);

  logic [HW-1:0] hold_q, hold_d;
  logic          rep_q, rep_d;
  logic          hold_hit;
`endif

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    s      = sync_q[SYNC_STAGES-1];
    toggle = (s != lvl_q) && (cnt_q == CW'(DB_CYCLES - 1));

    if ((s == lvl_q) || toggle) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    lvl_d  = toggle ? ~lvl_q : lvl_q;
    rise_d = toggle & ~lvl_q;
    fall_d = toggle & lvl_q;

`ifdef INPUT_CONDITIONER_REPEAT_EN
    // rep_q selects the first-delay target versus the steady repeat period
    hold_d   = hold_q;
    rep_d    = rep_q;
    hold_hit = REPEAT_ON && lvl_q && !toggle &&
               (hold_q == (rep_q ? HW'(REPEAT_PERIOD - 1) : HW'(REPEAT_DELAY - 1)));
    if (!REPEAT_ON || !lvl_q || toggle) begin
      hold_d = '0;
      rep_d  = 1'b0;
    end else if (hold_hit) begin
      hold_d = '0;
      rep_d  = 1'b1;
      rise_d = 1'b1;
    end else begin
      hold_d = hold_q + HW'(1);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
`ifdef INPUT_CONDITIONER_REPEAT_EN
      hold_q <= '0;
      rep_q  <= 1'b0;
`endif
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
`ifdef INPUT_CONDITIONER_REPEAT_EN
      hold_q <= hold_d;
      rep_q  <= rep_d;
`endif
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - multi-channel debounce/edge front end for PDU keys and switches
// Optional auto-repeat build: INPUT_CONDITIONER_REPEAT_EN.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int            CH            = PDU_CH,
  parameter int            DB_CYCLES     = DB_CYCLES_100MHZ_10MS,
  parameter int            SYNC_STAGES   = 2,
  parameter int            REPEAT_DELAY  = 50000000,
  parameter int            REPEAT_PERIOD = 10000000,
  parameter logic [CH-1:0] REPEAT_MASK   = {CH{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] raw,
  output logic [CH-1:0] lvl,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          any_rise
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    cond_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES)
`ifdef INPUT_CONDITIONER_REPEAT_EN
      ,
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .REPEAT_ON    (REPEAT_MASK[i])
`endif
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw_i (raw[i]),
      .lvl_o (lvl[i]),
      .rise_o(rise[i]),
      .fall_o(fall[i])
    );
  end

`ifndef INPUT_CONDITIONER_REPEAT_EN
  // Repeat parameters are inert in this build; this empty block only references them.
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || $bits(REPEAT_MASK) != CH) begin : g_repeat_cfg_unused
  end
`endif

  assign any_rise = |rise;

endmodule
